// File: rtl/vermi_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// Vermitypes_pkg
// Shared types for the vermi instruction sequencer. The state enum is kept
// here so trace/debug blocks can decode the sequencer state without
// duplicating the encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package Vermitypes_pkg;

    // Sequencer stages, one per instruction phase plus the bus-timeout trap.
    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        LOAD      = 3'd3,
        STORE     = 3'd4,
        WRITEBACK = 3'd5,
        TRAP      = 3'd6
    } vermi_state_t;

    // Execute-cycle counter covers latencies up to 16 (counts 0..15).
    localparam int EXEC_CNT_W    = 4;
    // Bus wait counter covers timeouts up to 255 cycles.
    localparam int TIMEOUT_CNT_W = 8;

endpackage

// File: rtl/vermi_timeout.sv
// ---------------------------------------------------------------------------
// vermi_timeout
// Counts consecutive bus wait cycles and flags the cycle in which the
// TIMEOUT-th wait cycle occurs.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   wait_cycle - bus request outstanding and not acknowledged this cycle
//   expired    - this cycle is the TIMEOUT-th consecutive wait cycle
// ---------------------------------------------------------------------------
module vermi_timeout
    import Vermitypes_pkg::*;
#(
    parameter int TIMEOUT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic wait_cycle,
    output logic expired
);

    localparam logic [TIMEOUT_CNT_W-1:0] LAST_WAIT = TIMEOUT_CNT_W'(TIMEOUT - 1);

    logic [TIMEOUT_CNT_W-1:0] wait_cnt;

    assign expired = wait_cycle && (wait_cnt == LAST_WAIT);

    // Any cycle that is not a wait cycle is either an acknowledged request
    // (which always changes state) or a stage without a bus request (which
    // was itself entered through a state change), so clearing whenever
    // wait_cycle is low is the same as clearing on every state change.
    // Expiry also clears because the sequencer moves to TRAP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (wait_cycle && !expired) begin
            wait_cnt <= wait_cnt + TIMEOUT_CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

endmodule

// File: rtl/vermi_sequencer.sv
// ---------------------------------------------------------------------------
// vermi_sequencer
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXECUTE ->
// (LOAD | STORE | WRITEBACK) -> FETCH, with an optional bus timeout trap and
// a retired-instruction counter.
// Ports:
//   clk            - clock, rising edge
//   reset          - asynchronous active-low reset
//   ready          - bus acknowledge for the current fetch/load/store
//   is_load, is_store, has_rd, is_multicycle - decoded instruction flags
//   valid          - bus request (fetch, load or store in progress)
//   fetch_en .. trap_en - one-hot stage enables
//   exec_last      - final EXECUTE cycle
//   bus_error      - one-cycle pulse in the TRAP cycle after a timeout
//   retired        - retired-instruction count, wraps silently
// ---------------------------------------------------------------------------
module vermi_sequencer
    import Vermitypes_pkg::*;
#(
    parameter int EXEC_LATENCY = 1,
    parameter int TIMEOUT      = 0,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ready,
    input  logic                   is_load,
    input  logic                   is_store,
    input  logic                   has_rd,
    input  logic                   is_multicycle,
    output logic                   valid,
    output logic                   fetch_en,
    output logic                   decode_en,
    output logic                   execute_en,
    output logic                   load_en,
    output logic                   store_en,
    output logic                   writeback_en,
    output logic                   trap_en,
    output logic                   exec_last,
    output logic                   bus_error,
    output logic [COUNT_WIDTH-1:0] retired
);

    if (EXEC_LATENCY < 1 || EXEC_LATENCY > 16) begin : g_bad_exec_latency
        $error("vermi_sequencer: EXEC_LATENCY must be in 1..16");
    end
    if (TIMEOUT < 0 || TIMEOUT > 255) begin : g_bad_timeout
        $error("vermi_sequencer: TIMEOUT must be in 0..255");
    end
    if (COUNT_WIDTH < 8 || COUNT_WIDTH > 64) begin : g_bad_count_width
        $error("vermi_sequencer: COUNT_WIDTH must be in 8..64");
    end

    localparam logic [EXEC_CNT_W-1:0]  EXEC_LAST_CNT = EXEC_CNT_W'(EXEC_LATENCY - 1);
    localparam logic [COUNT_WIDTH-1:0] RETIRE_ONE    = COUNT_WIDTH'(1);

    vermi_state_t          state;
    logic [EXEC_CNT_W-1:0] exec_cnt;
    logic                  timeout_hit;

    assign fetch_en     = (state == FETCH);
    assign decode_en    = (state == DECODE);
    assign execute_en   = (state == EXECUTE);
    assign load_en      = (state == LOAD);
    assign store_en     = (state == STORE);
    assign writeback_en = (state == WRITEBACK);
    assign trap_en      = (state == TRAP);
    assign valid        = fetch_en | load_en | store_en;

    // Single-cycle ops finish in their first EXECUTE cycle regardless of the
    // counter; multi-cycle ops finish once the counter has walked up to
    // EXEC_LATENCY-1.
    assign exec_last = execute_en & (~is_multicycle | (exec_cnt == EXEC_LAST_CNT));

    // The wait counter only exists when a timeout is configured; otherwise
    // the sequencer simply waits for ready forever.
    if (TIMEOUT > 0) begin : g_timeout
        vermi_timeout #(
            .TIMEOUT (TIMEOUT)
        ) u_timeout (
            .clk        (clk),
            .reset      (reset),
            .wait_cycle (valid & ~ready),
            .expired    (timeout_hit)
        );
    end else begin : g_no_timeout
        assign timeout_hit = 1'b0;
    end

    // Sequencer FSM. ready is tested before timeout_hit in every bus stage
    // so an acknowledge arriving on the expiry cycle still completes
    // normally. retired counts every completed instruction as it returns to
    // FETCH; the TRAP -> FETCH path abandons the instruction and is not
    // counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FETCH;
            exec_cnt  <= '0;
            retired   <= '0;
            bus_error <= 1'b0;
        end else begin
            bus_error <= 1'b0;
            case (state)
                FETCH: begin
                    if (ready) begin
                        state <= DECODE;
                    end else if (timeout_hit) begin
                        state     <= TRAP;
                        bus_error <= 1'b1;
                    end
                end
                DECODE: begin
                    state    <= EXECUTE;
                    exec_cnt <= '0;
                end
                EXECUTE: begin
                    if (exec_last) begin
                        if (is_load) begin
                            state <= LOAD;
                        end else if (is_store) begin
                            state <= STORE;
                        end else if (has_rd) begin
                            state <= WRITEBACK;
                        end else begin
                            state   <= FETCH;
                            retired <= retired + RETIRE_ONE;
                        end
                    end else begin
                        exec_cnt <= exec_cnt + EXEC_CNT_W'(1);
                    end
                end
                LOAD: begin
                    if (ready) begin
                        state <= WRITEBACK;
                    end else if (timeout_hit) begin
                        state     <= TRAP;
                        bus_error <= 1'b1;
                    end
                end
                STORE: begin
                    if (ready) begin
                        state   <= FETCH;
                        retired <= retired + RETIRE_ONE;
                    end else if (timeout_hit) begin
                        state     <= TRAP;
                        bus_error <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    state   <= FETCH;
                    retired <= retired + RETIRE_ONE;
                end
                TRAP: begin
                    state <= FETCH;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vermi_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vermi_sequencer
// Directed bench for vermi_sequencer. u0 uses EXEC_LATENCY=4, TIMEOUT=5,
// COUNT_WIDTH=8; u1 uses the defaults (no timeout, 32-bit counter). Both
// share the same inputs and every scenario starts from a fresh reset.
// ---------------------------------------------------------------------------
module tb_vermi_sequencer;

    localparam logic [6:0] ST_F = 7'b1000000;
    localparam logic [6:0] ST_D = 7'b0100000;
    localparam logic [6:0] ST_E = 7'b0010000;
    localparam logic [6:0] ST_L = 7'b0001000;
    localparam logic [6:0] ST_S = 7'b0000100;
    localparam logic [6:0] ST_W = 7'b0000010;
    localparam logic [6:0] ST_T = 7'b0000001;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ready = 1'b0;
    logic is_load = 1'b0;
    logic is_store = 1'b0;
    logic has_rd = 1'b0;
    logic is_multicycle = 1'b0;

    logic valid0, fetch_en0, decode_en0, execute_en0, load_en0, store_en0;
    logic writeback_en0, trap_en0, exec_last0, bus_error0;
    logic [7:0] retired0;

    logic valid1, fetch_en1, decode_en1, execute_en1, load_en1, store_en1;
    logic writeback_en1, trap_en1, exec_last1, bus_error1;
    logic [31:0] retired1;

    logic [6:0] stage0;
    logic [6:0] stage1;

    int checks = 0;
    int failures = 0;

    assign stage0 = {fetch_en0, decode_en0, execute_en0, load_en0, store_en0, writeback_en0, trap_en0};
    assign stage1 = {fetch_en1, decode_en1, execute_en1, load_en1, store_en1, writeback_en1, trap_en1};

    vermi_sequencer #(
        .EXEC_LATENCY (4),
        .TIMEOUT      (5),
        .COUNT_WIDTH  (8)
    ) u0 (
        .clk           (clk),
        .reset         (reset),
        .ready         (ready),
        .is_load       (is_load),
        .is_store      (is_store),
        .has_rd        (has_rd),
        .is_multicycle (is_multicycle),
        .valid         (valid0),
        .fetch_en      (fetch_en0),
        .decode_en     (decode_en0),
        .execute_en    (execute_en0),
        .load_en       (load_en0),
        .store_en      (store_en0),
        .writeback_en  (writeback_en0),
        .trap_en       (trap_en0),
        .exec_last     (exec_last0),
        .bus_error     (bus_error0),
        .retired       (retired0)
    );

    vermi_sequencer u1 (
        .clk           (clk),
        .reset         (reset),
        .ready         (ready),
        .is_load       (is_load),
        .is_store      (is_store),
        .has_rd        (has_rd),
        .is_multicycle (is_multicycle),
        .valid         (valid1),
        .fetch_en      (fetch_en1),
        .decode_en     (decode_en1),
        .execute_en    (execute_en1),
        .load_en       (load_en1),
        .store_en      (store_en1),
        .writeback_en  (writeback_en1),
        .trap_en       (trap_en1),
        .exec_last     (exec_last1),
        .bus_error     (bus_error1),
        .retired       (retired1)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle 1ns past the rising edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic ld, input logic st, input logic rd, input logic mc);
        is_load       = ld;
        is_store      = st;
        has_rd        = rd;
        is_multicycle = mc;
    endtask

    // Reset over two edges, released 1ns after an edge with ready low.
    task automatic do_reset;
        reset = 1'b0;
        ready = 1'b0;
        set_flags(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (stage0 !== ST_F) begin failures++; $display("[TB] FAIL reset_stage got=%b exp=%b", stage0, ST_F); end
        checks++; if (valid0 !== 1'b1) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=1", valid0); end
        checks++; if (exec_last0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_exec_last got=%b exp=0", exec_last0); end
        checks++; if (bus_error0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_bus_error got=%b exp=0", bus_error0); end
        checks++; if (retired0 !== 8'd0) begin failures++; $display("[TB] FAIL reset_retired got=%0d exp=0", retired0); end
        checks++; if (stage1 !== ST_F) begin failures++; $display("[TB] FAIL reset_stage_u1 got=%b exp=%b", stage1, ST_F); end
        checks++; if (retired1 !== 32'd0) begin failures++; $display("[TB] FAIL reset_retired_u1 got=%0d exp=0", retired1); end
    endtask

    task automatic test_alu;
        do_reset();
        ready = 1'b1;
        step();
        checks++; if (stage0 !== ST_D) begin failures++; $display("[TB] FAIL alu_decode got=%b exp=%b", stage0, ST_D); end
        step();
        checks++; if (stage0 !== ST_E) begin failures++; $display("[TB] FAIL alu_execute got=%b exp=%b", stage0, ST_E); end
        checks++; if (exec_last0 !== 1'b1) begin failures++; $display("[TB] FAIL alu_exec_last got=%b exp=1", exec_last0); end
        checks++; if (valid0 !== 1'b0) begin failures++; $display("[TB] FAIL alu_valid_exec got=%b exp=0", valid0); end
        checks++; if (exec_last1 !== 1'b1) begin failures++; $display("[TB] FAIL alu_exec_last_u1 got=%b exp=1", exec_last1); end
        checks++; if (retired0 !== 8'd0) begin failures++; $display("[TB] FAIL alu_retired_before got=%0d exp=0", retired0); end
        step();
        checks++; if (stage0 !== ST_F) begin failures++; $display("[TB] FAIL alu_back_fetch got=%b exp=%b", stage0, ST_F); end
        checks++; if (retired0 !== 8'd1) begin failures++; $display("[TB] FAIL alu_retired got=%0d exp=1", retired0); end
        checks++; if (retired1 !== 32'd1) begin failures++; $display("[TB] FAIL alu_retired_u1 got=%0d exp=1", retired1); end
    endtask

    task automatic test_multicycle;
        do_reset();
        ready = 1'b1;
        set_flags(1'b0, 1'b0, 1'b1, 1'b1);
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            checks++; if (stage0 !== ST_E) begin failures++; $display("[TB] FAIL mc_execute[%0d] got=%b exp=%b", i, stage0, ST_E); end
            checks++; if (exec_last0 !== (i == 3)) begin failures++; $display("[TB] FAIL mc_exec_last[%0d] got=%b exp=%b", i, exec_last0, (i == 3)); end
            step();
        end
        checks++; if (stage0 !== ST_W) begin failures++; $display("[TB] FAIL mc_writeback got=%b exp=%b", stage0, ST_W); end
        checks++; if (retired0 !== 8'd0) begin failures++; $display("[TB] FAIL mc_retired_wb got=%0d exp=0", retired0); end
        step();
        checks++; if (stage0 !== ST_F) begin failures++; $display("[TB] FAIL mc_fetch got=%b exp=%b", stage0, ST_F); end
        checks++; if (retired0 !== 8'd1) begin failures++; $display("[TB] FAIL mc_retired got=%0d exp=1", retired0); end
    endtask

    task automatic test_load_wait;
        do_reset();
        ready = 1'b1;
        set_flags(1'b1, 1'b0, 1'b1, 1'b0);
        step();
        step();
        ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) ready = 1'b1;
            checks++; if (stage0 !== ST_L) begin failures++; $display("[TB] FAIL load_hold[%0d] got=%b exp=%b", i, stage0, ST_L); end
            checks++; if (valid0 !== 1'b1) begin failures++; $display("[TB] FAIL load_valid[%0d] got=%b exp=1", i, valid0); end
            step();
        end
        checks++; if (stage0 !== ST_W) begin failures++; $display("[TB] FAIL load_writeback got=%b exp=%b", stage0, ST_W); end
        step();
        checks++; if (stage0 !== ST_F) begin failures++; $display("[TB] FAIL load_fetch got=%b exp=%b", stage0, ST_F); end
        checks++; if (retired0 !== 8'd1) begin failures++; $display("[TB] FAIL load_retired got=%0d exp=1", retired0); end
    endtask

    task automatic test_store;
        do_reset();
        ready = 1'b1;
        set_flags(1'b0, 1'b1, 1'b0, 1'b0);
        step();
        step();
        ready = 1'b0;
        step();
        checks++; if (stage0 !== ST_S) begin failures++; $display("[TB] FAIL store_enter got=%b exp=%b", stage0, ST_S); end
        checks++; if (valid0 !== 1'b1) begin failures++; $display("[TB] FAIL store_valid got=%b exp=1", valid0); end
        step();
        checks++; if (stage0 !== ST_S) begin failures++; $display("[TB] FAIL store_hold got=%b exp=%b", stage0, ST_S); end
        checks++; if (retired0 !== 8'd0) begin failures++; $display("[TB] FAIL store_retired_wait got=%0d exp=0", retired0); end
        ready = 1'b1;
        step();
        checks++; if (stage0 !== ST_F) begin failures++; $display("[TB] FAIL store_fetch got=%b exp=%b", stage0, ST_F); end
        checks++; if (retired0 !== 8'd1) begin failures++; $display("[TB] FAIL store_retired got=%0d exp=1", retired0); end
    endtask

    task automatic test_timeout;
        // One ALU op first so the trap can be shown not to retire.
        do_reset();
        ready = 1'b1;
        repeat (3) step();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (stage0 !== ST_F) begin failures++; $display("[TB] FAIL to_wait[%0d] got=%b exp=%b", i, stage0, ST_F); end
            checks++; if (bus_error0 !== 1'b0) begin failures++; $display("[TB] FAIL to_no_error[%0d] got=%b exp=0", i, bus_error0); end
            step();
        end
        checks++; if (stage0 !== ST_T) begin failures++; $display("[TB] FAIL to_trap got=%b exp=%b", stage0, ST_T); end
        checks++; if (bus_error0 !== 1'b1) begin failures++; $display("[TB] FAIL to_bus_error got=%b exp=1", bus_error0); end
        checks++; if (valid0 !== 1'b0) begin failures++; $display("[TB] FAIL to_trap_valid got=%b exp=0", valid0); end
        step();
        checks++; if (stage0 !== ST_F) begin failures++; $display("[TB] FAIL to_refetch got=%b exp=%b", stage0, ST_F); end
        checks++; if (bus_error0 !== 1'b0) begin failures++; $display("[TB] FAIL to_pulse_end got=%b exp=0", bus_error0); end
        checks++; if (retired0 !== 8'd1) begin failures++; $display("[TB] FAIL to_retired got=%0d exp=1", retired0); end
        checks++; if (stage1 !== ST_F) begin failures++; $display("[TB] FAIL nto_wait_u1 got=%b exp=%b", stage1, ST_F); end
        checks++; if (bus_error1 !== 1'b0) begin failures++; $display("[TB] FAIL nto_bus_error_u1 got=%b exp=0", bus_error1); end
        checks++; if (valid1 !== 1'b1) begin failures++; $display("[TB] FAIL nto_valid_u1 got=%b exp=1", valid1); end

        // Acknowledge on the expiry cycle: ready wins.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
        end
        ready = 1'b1;
        checks++; if (stage0 !== ST_F) begin failures++; $display("[TB] FAIL to_edge_fetch got=%b exp=%b", stage0, ST_F); end
        step();
        checks++; if (stage0 !== ST_D) begin failures++; $display("[TB] FAIL to_edge_decode got=%b exp=%b", stage0, ST_D); end
        checks++; if (bus_error0 !== 1'b0) begin failures++; $display("[TB] FAIL to_edge_no_error got=%b exp=0", bus_error0); end
    endtask

    task automatic test_wrap;
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 255; i++) begin
            repeat (3) step();
        end
        checks++; if (retired0 !== 8'd255) begin failures++; $display("[TB] FAIL wrap_255 got=%0d exp=255", retired0); end
        checks++; if (retired1 !== 32'd255) begin failures++; $display("[TB] FAIL wrap_255_u1 got=%0d exp=255", retired1); end
        repeat (3) step();
        checks++; if (retired0 !== 8'd0) begin failures++; $display("[TB] FAIL wrap_zero got=%0d exp=0", retired0); end
        checks++; if (retired1 !== 32'd256) begin failures++; $display("[TB] FAIL wrap_256_u1 got=%0d exp=256", retired1); end
        checks++; if (stage0 !== ST_F) begin failures++; $display("[TB] FAIL wrap_stage got=%b exp=%b", stage0, ST_F); end
    endtask

    task automatic test_reset_mid_exec;
        do_reset();
        ready = 1'b1;
        repeat (3) step();
        set_flags(1'b0, 1'b0, 1'b1, 1'b1);
        step();
        step();
        step();
        checks++; if (stage0 !== ST_E) begin failures++; $display("[TB] FAIL rst_mid_pre got=%b exp=%b", stage0, ST_E); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (stage0 !== ST_F) begin failures++; $display("[TB] FAIL rst_mid_stage got=%b exp=%b", stage0, ST_F); end
        checks++; if (retired0 !== 8'd0) begin failures++; $display("[TB] FAIL rst_mid_retired got=%0d exp=0", retired0); end
        checks++; if (exec_last0 !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_exec_last got=%b exp=0", exec_last0); end
        checks++; if (valid0 !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_valid got=%b exp=1", valid0); end
        step();
        reset = 1'b1;
        checks++; if (stage0 !== ST_F) begin failures++; $display("[TB] FAIL rst_rel_fetch got=%b exp=%b", stage0, ST_F); end
        step();
        checks++; if (stage0 !== ST_D) begin failures++; $display("[TB] FAIL rst_rel_decode got=%b exp=%b", stage0, ST_D); end
        step();
        checks++; if (exec_last0 !== 1'b0) begin failures++; $display("[TB] FAIL rst_rel_exec_first got=%b exp=0", exec_last0); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_multicycle();
        test_load_wait();
        test_store();
        test_timeout();
        test_wrap();
        test_reset_mid_exec();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
